crc_serializer: RTL and testbench

- Upstream feeder for the serial CRC engine.
- Accepts parallel bytes over a valid/ready handshake and drives the engine's DATA/ACTIVE inputs LSB-first, one bit per clock.
- Watches the engine's Valid output so that a new frame is never started while the CRC is still being shifted out.
- Flags frame completion and protocol errors (Valid missing or dropping early).

---
 rtl/crc_ser_pkg.sv | 30 +++
 rtl/crc_serializer.sv | 187 ++++++++++++++++++
 tb/tb_crc_serializer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_ser_pkg.sv
// Shared definitions for the CRC serializer: FSM state encoding, default
// sizing constants and a counter-width helper.
package crc_ser_pkg;

    // Serializer FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT    = 3'd1,
        ST_WAIT_CRC = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_GAP      = 3'd4
    } state_e;

    // Default configuration.
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CRC_WIDTH  = 8;
    localparam int DEF_TIMEOUT    = 16;
    localparam int DEF_GAP_CYCLES = 2;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Counter widths for the default configuration.
    localparam int DEF_BIT_CNT_W = cnt_w(DEF_DATA_WIDTH);
    localparam int DEF_DR_CNT_W  = cnt_w(DEF_CRC_WIDTH + 1);
    localparam int DEF_TO_CNT_W  = cnt_w(DEF_TIMEOUT);

endpackage

// File: rtl/crc_serializer.sv
// Upstream feeder for the serial CRC engine: takes parallel words over a
// valid/ready handshake, shifts them out LSB-first on DATA/ACTIVE, then
// supervises the engine's CRC_VALID drain before allowing the next frame.
// Define CRC_SER_BURST_EN to allow multi-word frames (IN_LAST terminates).
module crc_serializer
    import crc_ser_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CRC_WIDTH  = DEF_CRC_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  IN_VALID,
    input  logic                  IN_LAST,
    output logic                  IN_READY,
    input  logic                  CRC_VALID,
    output logic                  DATA,
    output logic                  ACTIVE,
    output logic                  BUSY,
    output logic                  FRAME_DONE,
    output logic                  ERR
);

    localparam int BIT_W = cnt_w(DATA_WIDTH);
    localparam int DR_W  = cnt_w(CRC_WIDTH + 1);
    // tocnt times both the CRC_VALID timeout and the inter-frame gap.
    localparam int TO_W  = cnt_w((TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(CRC_WIDTH - 1);
    localparam logic [DR_W-1:0]  DR_FULL  = DR_W'(CRC_WIDTH);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  GAP_LAST = TO_W'(GAP_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]        bitcnt_q, bitcnt_d;
    logic [TO_W-1:0]         tocnt_q, tocnt_d;
    logic [DR_W-1:0]         drcnt_q, drcnt_d;
    logic                    data_q, data_d;
    logic                    active_q, active_d;
    logic                    in_ready_q, in_ready_d;
    logic                    frame_done_q, frame_done_d;
    logic                    err_q, err_d;
    logic                    accept;

`ifdef CRC_SER_BURST_EN
    logic                    last_q, last_d;
`else
    logic                    unused_in_last;
    assign unused_in_last = IN_LAST;
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        tocnt_d      = tocnt_q;
        drcnt_d      = drcnt_q;
        data_d       = 1'b0;
        active_d     = 1'b0;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
`ifdef CRC_SER_BURST_EN
        last_d       = last_q;
`endif
        // in_ready_q is only high in IDLE or the burst-continuation slot.
        accept = IN_VALID && in_ready_q;

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_SHIFT: begin
                if (bitcnt_q != BIT_LAST) begin
                    data_d   = shreg_q[0];
                    active_d = 1'b1;
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + BIT_W'(1);
                end else if (!accept) begin
                    state_d = ST_WAIT_CRC;
                    tocnt_d = '0;
                end
            end
            ST_WAIT_CRC: begin
                if (CRC_VALID) begin
                    state_d = ST_DRAIN;
                    drcnt_d = DR_W'(1);
                end else if (tocnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_GAP;
                    tocnt_d = '0;
                end else begin
                    tocnt_d = tocnt_q + TO_W'(1);
                end
            end
            ST_DRAIN: begin
                if (!CRC_VALID) begin
                    err_d   = 1'b1;
                    state_d = ST_GAP;
                    tocnt_d = '0;
                end else if (drcnt_q >= DR_LAST) begin
                    frame_done_d = 1'b1;
                    drcnt_d      = DR_FULL;
                    state_d      = ST_GAP;
                    tocnt_d      = '0;
                end else begin
                    drcnt_d = drcnt_q + DR_W'(1);
                end
            end
            ST_GAP: begin
                if (tocnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    tocnt_d = tocnt_q + TO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new word always starts presenting bit 0 on its accept edge.
        if (accept) begin
            state_d  = ST_SHIFT;
            data_d   = IN_DATA[0];
            active_d = 1'b1;
            shreg_d  = IN_DATA >> 1;
            bitcnt_d = '0;
`ifdef CRC_SER_BURST_EN
            last_d   = IN_LAST;
`endif
        end

`ifdef CRC_SER_BURST_EN
        in_ready_d = (state_d == ST_IDLE) ||
                     ((state_d == ST_SHIFT) && (bitcnt_d == BIT_LAST) && !last_d);
`else
        in_ready_d = (state_d == ST_IDLE);
`endif
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: reset clears every flop, including the shift register, so a
        // half-shifted word can never leak into the next frame.
        if (!RST) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            tocnt_q      <= '0;
            drcnt_q      <= '0;
            data_q       <= 1'b0;
            active_q     <= 1'b0;
            in_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef CRC_SER_BURST_EN
            last_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            tocnt_q      <= tocnt_d;
            drcnt_q      <= drcnt_d;
            data_q       <= data_d;
            active_q     <= active_d;
            in_ready_q   <= in_ready_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
`ifdef CRC_SER_BURST_EN
            last_q       <= last_d;
`endif
        end
    end

    assign DATA       = data_q;
    assign ACTIVE     = active_q;
    assign IN_READY   = in_ready_q;
    assign FRAME_DONE = frame_done_q;
    assign ERR        = err_q;
    assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crc_serializer.sv
// Self-checking bench for crc_serializer. Each frame's full output trace is
// predicted from the word bits and the CRC_VALID schedule with plain
// arithmetic and compared cycle by cycle.
module tb_crc_serializer;

    localparam int DW  = 8;
    localparam int CW  = 8;
    localparam int TO  = 16;
    localparam int GAP = 2;
`ifdef CRC_SER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] IN_DATA = '0;
    logic          IN_VALID = 1'b0;
    logic          IN_LAST = 1'b0;
    logic          IN_READY;
    logic          CRC_VALID = 1'b0;
    logic          DATA;
    logic          ACTIVE;
    logic          BUSY;
    logic          FRAME_DONE;
    logic          ERR;

    logic [5:0]    obs;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] words[$];

    crc_serializer #(
        .DATA_WIDTH (DW),
        .CRC_WIDTH  (CW),
        .TIMEOUT    (TO),
        .GAP_CYCLES (GAP)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IN_DATA    (IN_DATA),
        .IN_VALID   (IN_VALID),
        .IN_LAST    (IN_LAST),
        .IN_READY   (IN_READY),
        .CRC_VALID  (CRC_VALID),
        .DATA       (DATA),
        .ACTIVE     (ACTIVE),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    assign obs = {ACTIVE, DATA, IN_READY, BUSY, FRAME_DONE, ERR};

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Offer words[] as one frame, drive CRC_VALID high for len cycles starting
    // d cycles after ACTIVE falls, and check every cycle until IN_READY returns.
    task automatic run_frame(input int d, input int len, input bit hold,
                             input logic [DW-1:0] hold_byte);
        int         nw, nb, e, s_end, waited;
        bit         is_done, rdy;
        logic [5:0] exp_v;
        nw = words.size();
        nb = DW * nw;
        if (len == 0 || d >= TO) begin
            e = nb + TO;          is_done = 1'b0;
        end else if (len >= CW) begin
            e = nb + d + CW;      is_done = 1'b1;
        end else begin
            e = nb + d + len + 1; is_done = 1'b0;
        end
        s_end = e + GAP;

        CRC_VALID = 1'b0;
        IN_DATA   = words[0];
        IN_LAST   = (nw == 1);
        IN_VALID  = 1'b1;
        waited    = 0;
        rdy       = 1'b0;
        while (!rdy && waited < 100) begin
            rdy = IN_READY;
            step();
            waited++;
        end
        n_checks++;
        if (!rdy) begin
            n_fail++;
            $display("FAIL accept_wait: IN_READY got 0 for %0d cycles, required 1", waited);
            IN_VALID = 1'b0;
            return;
        end

        for (int s = 0; s <= s_end; s++) begin
            exp_v[5] = (s < nb);
            exp_v[4] = (s < nb) ? words[s / DW][s % DW] : 1'b0;
            exp_v[3] = (s == s_end) ||
                       (BURST && (s % DW == DW - 1) && (s / DW < nw - 1));
            exp_v[2] = (s < s_end);
            exp_v[1] = is_done && (s == e);
            exp_v[0] = !is_done && (s == e);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL frame_trace w0=%h s=%0d: {ACTIVE,DATA,IN_READY,BUSY,FRAME_DONE,ERR} got %b required %b",
                         words[0], s, obs, exp_v);
            end
            if (s == s_end) begin
                CRC_VALID = 1'b0;
                IN_VALID  = hold;
            end else begin
                CRC_VALID = (s >= nb + d) && (s < nb + d + len);
                if (BURST && (s % DW == DW - 1) && (s / DW < nw - 1)) begin
                    IN_VALID = 1'b1;
                    IN_DATA  = words[s / DW + 1];
                    IN_LAST  = (s / DW + 1 == nw - 1);
                end else if (hold) begin
                    IN_VALID = 1'b1;
                    IN_DATA  = hold_byte;
                    IN_LAST  = 1'b1;
                end else begin
                    IN_VALID = 1'($urandom_range(0, 1));
                    IN_DATA  = DW'($urandom);
                    IN_LAST  = 1'($urandom_range(0, 1));
                end
                step();
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (2) step();
        n_checks++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 000000", obs);
        end
        RST = 1'b1;
        #1;
        n_checks++;
        if ({IN_READY, BUSY} !== 2'b00) begin
            n_fail++;
            $display("FAIL ready_after_release: {IN_READY,BUSY} got %b required 00", {IN_READY, BUSY});
        end
        step();
        n_checks++;
        if ({IN_READY, BUSY} !== 2'b10) begin
            n_fail++;
            $display("FAIL ready_first_edge: {IN_READY,BUSY} got %b required 10", {IN_READY, BUSY});
        end
    endtask

    task automatic test_single_frames();
        words = '{8'hA5}; run_frame(0, CW, 1'b0, 8'h00);
        words = '{8'h5A}; run_frame(1, CW, 1'b0, 8'h00);
        words = '{8'hC3}; run_frame(0, 0, 1'b0, 8'h00);
        words = '{8'h0F}; run_frame(0, 5, 1'b0, 8'h00);
        words = '{8'hF0}; run_frame(TO - 1, CW, 1'b0, 8'h00);
        words = '{8'h00}; run_frame(2, 1, 1'b0, 8'h00);
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 12; i++) begin
            words = '{DW'($urandom)};
            run_frame(int'($urandom_range(0, 18)), int'($urandom_range(0, 11)), 1'b0, 8'h00);
        end
        if (BURST) begin
            words = '{DW'($urandom), DW'($urandom), DW'($urandom)};
            run_frame(int'($urandom_range(0, 3)), CW, 1'b0, 8'h00);
        end
    endtask

    task automatic test_reset_mid_frame();
        int waited;
        IN_DATA  = 8'h3C;
        IN_LAST  = 1'b1;
        IN_VALID = 1'b1;
        waited   = 0;
        while (IN_READY !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        step();
        IN_VALID = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({ACTIVE, DATA} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_frame_bit3: {ACTIVE,DATA} got %b required 11", {ACTIVE, DATA});
        end
        #2;
        RST = 1'b0;
        #1;
        n_checks++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b required 000000", obs);
        end
        repeat (2) step();
        n_checks++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL held_reset: got %b required 000000", obs);
        end
        RST = 1'b1;
        words = '{8'h81};
        run_frame(0, CW, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        if (BURST) begin
            words = '{8'h12, 8'h34};
            run_frame(0, CW, 1'b0, 8'h00);
        end else begin
            words = '{8'h12};
            run_frame(0, CW, 1'b1, 8'h34);
            words = '{8'h34};
            run_frame(1, CW, 1'b0, 8'h00);
        end
    endtask

    initial begin
        test_reset();
        test_single_frames();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
